// File: rtl/fp32_mul_issue_arbiter_pkg.sv
// Shared FP unit types for the multiplier issue arbiter.
// Tags are sized for the largest supported requester count (8), so one
// result-queue entry layout serves every NUM_REQ configuration.
package FPUTypes;

  localparam int unsigned FMUL_ARB_MAX_REQ = 8;
  localparam int unsigned FMUL_ARB_TAG_W   = $clog2(FMUL_ARB_MAX_REQ);

  typedef logic [FMUL_ARB_TAG_W-1:0] FMulArbTagPath;

  typedef struct packed {
    FMulArbTagPath tag;
    logic [31:0]   data;
  } FMulArbResultPath;

endpackage

// File: rtl/fp32_mul_issue_arbiter_fmul.sv
// FP32PipelinedMultiplier: IEEE-754 single-precision multiply, round to
// nearest even, denormal inputs and underflowed results flushed to signed
// zero, any NaN or inf*0 producing the canonical quiet NaN 0x7FC00000.
// Latency is PIPELINE_DEPTH-1 clocks, one new operation per clock, no stall.
// Ports: clk; lhs/rhs operands; product result.
module FP32PipelinedMultiplier #(
  parameter int unsigned PIPELINE_DEPTH = 5
) (
  input  logic        clk,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  output logic [31:0] product
);

  localparam int unsigned STAGES = PIPELINE_DEPTH - 1;

  logic        sign;
  logic        lhs_zero, rhs_zero, lhs_inf, rhs_inf, lhs_nan, rhs_nan;
  logic [47:0] prod;
  logic [9:0]  exp_sum;
  logic [22:0] keep;
  logic        guard, sticky;
  logic [23:0] mant_r;
  logic [31:0] result_c;
  logic [31:0] pipe [STAGES];

  // Full multiply in one combinational cone; the delay line below lets
  // register retiming spread it over the pipeline.
  always_comb begin
    sign     = lhs[31] ^ rhs[31];
    lhs_zero = (lhs[30:23] == 8'h00);
    rhs_zero = (rhs[30:23] == 8'h00);
    lhs_inf  = (lhs[30:23] == 8'hFF) && (lhs[22:0] == 23'd0);
    rhs_inf  = (rhs[30:23] == 8'hFF) && (rhs[22:0] == 23'd0);
    lhs_nan  = (lhs[30:23] == 8'hFF) && (lhs[22:0] != 23'd0);
    rhs_nan  = (rhs[30:23] == 8'hFF) && (rhs[22:0] != 23'd0);
    keep     = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    prod     = 48'({1'b1, lhs[22:0]}) * 48'({1'b1, rhs[22:0]});
    exp_sum  = 10'(lhs[30:23]) + 10'(rhs[30:23]) - 10'd127;
    // Significand product lies in [1,4): normalise by at most one place.
    if (prod[47]) begin
      keep    = prod[46:24];
      guard   = prod[23];
      sticky  = |prod[22:0];
      exp_sum = exp_sum + 10'd1;
    end else begin
      keep    = prod[45:23];
      guard   = prod[22];
      sticky  = |prod[21:0];
    end
    mant_r   = {1'b0, keep} + {23'd0, guard & (sticky | keep[0])};
    // Rounding carry-out leaves a zero fraction and bumps the exponent.
    exp_sum  = exp_sum + 10'(mant_r[23]);
    result_c = {sign, exp_sum[7:0], mant_r[22:0]};
    if ($signed(exp_sum) >= 10'sd255) begin
      result_c = {sign, 8'hFF, 23'd0};
    end else if ($signed(exp_sum) <= 10'sd0) begin
      result_c = {sign, 31'd0};
    end
    if (lhs_nan | rhs_nan | (lhs_inf & rhs_zero) | (rhs_inf & lhs_zero)) begin
      result_c = 32'h7FC0_0000;
    end else if (lhs_inf | rhs_inf) begin
      result_c = {sign, 8'hFF, 23'd0};
    end else if (lhs_zero | rhs_zero) begin
      result_c = {sign, 31'd0};
    end
  end

  // Data-only delay line; ownership is tracked by the caller's valid bits.
  always_ff @(posedge clk) begin
    pipe[0] <= result_c;
    for (int i = 1; i < STAGES; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end

  assign product = pipe[STAGES-1];

endmodule

// File: rtl/fp32_mul_issue_arbiter_result_queue.sv
// fp32_mul_result_queue: synchronous FIFO of {tag, data} results.
// Push and pop may coincide, also when full (the popped slot is the one
// being overwritten). Head is registered storage; no empty-queue bypass.
// Ports: clk, rst_n; push/push_data; pop; full, empty; head.
module fp32_mul_result_queue
  import FPUTypes::*;
#(
  parameter int unsigned DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  FMulArbResultPath push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output FMulArbResultPath head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  FMulArbResultPath   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (32'(wr_ptr) == DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (32'(rd_ptr) == DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage is not reset; stale entries are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fp32_mul_issue_arbiter.sv
// fp32_mul_issue_arbiter: round-robin issue of NUM_REQ requesters into one
// shared non-stalling FP32 multiplier, with a credit-protected result queue.
// Ports: clk, rst_n; req_valid/req_lhs/req_rhs in, req_ready one-hot grant;
// res_valid/res_ready handshake with res_tag (owner) and res_data (product);
// busy while any operation is in flight or queued.
module fp32_mul_issue_arbiter
  import FPUTypes::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned PIPELINE_DEPTH = 5,
  parameter int unsigned RESULT_DEPTH   = PIPELINE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0][31:0]   req_lhs,
  input  logic [NUM_REQ-1:0][31:0]   req_rhs,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(NUM_REQ)-1:0] res_tag,
  output logic [31:0]                res_data,
  output logic                       busy
);

  localparam int unsigned TAG_W  = $clog2(NUM_REQ);
  localparam int unsigned TP_LEN = PIPELINE_DEPTH - 1;
  localparam int unsigned CRED_W = $clog2(RESULT_DEPTH + 1);

  logic [CRED_W-1:0] cred;
  logic [TAG_W-1:0]  rr_ptr;
  logic [TAG_W-1:0]  grant_idx;
  logic              grant_any;
  int unsigned       cand;
  logic              can_issue, accept, deq;
  logic [31:0]       mul_lhs, mul_rhs, mul_product;
  logic              tp_valid [TP_LEN];
  FMulArbTagPath     tp_tag   [TP_LEN];
  FMulArbResultPath  q_push_data, q_head;
  logic              q_full, q_empty;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_ptr) + 32'(k)) % NUM_REQ;
      if (!grant_any && req_valid[TAG_W'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = TAG_W'(cand);
      end
    end
  end

  assign can_issue = (cred < CRED_W'(RESULT_DEPTH));
  assign accept    = grant_any & can_issue;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign deq       = res_valid & res_ready;
  assign busy      = (cred != '0);

  // Zeros when idle keep the multiplier inputs quiet; that result is dropped.
  assign mul_lhs = accept ? req_lhs[grant_idx] : '0;
  assign mul_rhs = accept ? req_rhs[grant_idx] : '0;

  FP32PipelinedMultiplier #(
    .PIPELINE_DEPTH (PIPELINE_DEPTH)
  ) u_fmul (
    .clk     (clk),
    .lhs     (mul_lhs),
    .rhs     (mul_rhs),
    .product (mul_product)
  );

  // Credits count accepted-but-not-dequeued operations; pointer advances past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cred   <= '0;
      rr_ptr <= '0;
    end else begin
      if (accept && !deq) begin
        cred <= cred + 1'b1;
      end else if (deq && !accept) begin
        cred <= cred - 1'b1;
      end
      if (accept) begin
        rr_ptr <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Valid half of the tag pipe, aligned with the multiplier latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TP_LEN; i++) begin
        tp_valid[i] <= 1'b0;
      end
    end else begin
      tp_valid[0] <= accept;
      for (int i = 1; i < TP_LEN; i++) begin
        tp_valid[i] <= tp_valid[i-1];
      end
    end
  end

  // Tag half of the tag pipe; only meaningful under its valid bit.
  always_ff @(posedge clk) begin
    tp_tag[0] <= FMUL_ARB_TAG_W'(grant_idx);
    for (int i = 1; i < TP_LEN; i++) begin
      tp_tag[i] <= tp_tag[i-1];
    end
  end

  assign q_push_data = '{tag: tp_tag[TP_LEN-1], data: mul_product};

  fp32_mul_result_queue #(
    .DEPTH (RESULT_DEPTH)
  ) u_resq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tp_valid[TP_LEN-1]),
    .push_data (q_push_data),
    .pop       (deq),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  assign res_valid = !q_empty;
  assign res_tag   = TAG_W'(q_head.tag);
  assign res_data  = q_head.data;

  // Credits bound occupancy: a push can only meet a full queue alongside a pop.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(tp_valid[TP_LEN-1] && q_full && !deq));
    end
  end

endmodule

// File: tb/tb_fp32_mul_issue_arbiter.sv
module tb_fp32_mul_issue_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned D  = 5;
  localparam int unsigned RD = 5;
  localparam int unsigned TW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0][31:0]   req_lhs;
  logic [N-1:0][31:0]   req_rhs;
  logic [N-1:0]         req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [TW-1:0]        res_tag;
  logic [31:0]          res_data;
  logic                 busy;

  always #5 clk = ~clk;

  fp32_mul_issue_arbiter #(
    .NUM_REQ        (N),
    .PIPELINE_DEPTH (D),
    .RESULT_DEPTH   (RD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_lhs   (req_lhs),
    .req_rhs   (req_rhs),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_tag   (res_tag),
    .res_data  (res_data),
    .busy      (busy)
  );

  typedef struct { int due; int tag; logic [31:0] data; } fl_t;
  typedef struct { int tag; logic [31:0] data; } rq_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_rr, m_cred, cyc;
  fl_t         m_fly[$];
  rq_t         m_q[$];
  logic [N-1:0] obs_acc;
  logic        obs_deq;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] to64(input logic [31:0] x);
    return {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
  endfunction

  // Exact product in double precision, then round-to-nearest-even to single.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    bit          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, g, st;
    real         rp;
    logic [63:0] d;
    logic [23:0] m;
    int          e;
    s      = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
    if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {s, 31'd0};
    rp = $bitstoreal(to64(a)) * $bitstoreal(to64(b));
    d  = $realtobits(rp);
    e  = int'(d[62:52]) - 1023 + 127;
    m  = {1'b0, d[51:29]};
    g  = d[28];
    st = |d[27:0];
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m = '0;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_lhs[i] = rand_fp();
      req_rhs[i] = rand_fp();
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fly.delete();
    m_cred = 0;
    m_rr   = 0;
  endtask

  // One clock: compare against the transaction model, then advance it.
  task automatic tick();
    int          g;
    int          idx;
    bit          deq;
    logic [31:0] el, er;
    fl_t         f;
    #1;
    g = -1;
    el = '0;
    er = '0;
    if (m_cred < RD) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && req_valid[idx[TW-1:0]]) g = idx;
      end
    end
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("res_valid", 32'(res_valid), 32'(m_q.size() > 0));
    chk("busy", 32'(busy), 32'(m_cred != 0));
    if (m_q.size() > 0) begin
      chk("res_tag", 32'(res_tag), 32'(m_q[0].tag));
      chk("res_data", res_data, m_q[0].data);
    end
    deq     = (m_q.size() > 0) && res_ready;
    obs_acc = req_valid & req_ready;
    obs_deq = res_valid & res_ready;
    if (g >= 0) begin
      el = req_lhs[g[TW-1:0]];
      er = req_rhs[g[TW-1:0]];
    end
    @(posedge clk);
    if (deq) void'(m_q.pop_front());
    if (m_fly.size() > 0 && m_fly[0].due == cyc) begin
      f = m_fly.pop_front();
      m_q.push_back('{f.tag, f.data});
    end
    if (g >= 0) begin
      m_fly.push_back('{cyc + D - 1, g, ref_mul(el, er)});
      m_cred++;
      m_rr = (g + 1) % N;
    end
    if (deq) m_cred--;
    cyc++;
    #1;
  endtask

  initial begin
    int n_acc;
    int n_deq;
    int n_stale;
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    req_lhs   = '0;
    req_rhs   = '0;
    cyc       = 0;
    model_reset();

    // Reset state
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round robin: all four requesting -> grants 0,1,2,3,0, results in order from cycle 5
    req_valid = 4'hF;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      #1;
      chk("rr_grant", 32'(req_ready), 32'd1 << (i % 4));
      tick();
    end
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_res_valid", 32'(res_valid), 32'd1);
      chk("rr_res_tag", 32'(res_tag), 32'(i % 4));
      tick();
    end
    repeat (3) tick();

    // Single issue from requester 2: 2.0 * 3.0 = 6.0 in cycle 5
    req_lhs[2] = 32'h4000_0000;
    req_rhs[2] = 32'h4040_0000;
    req_valid  = 4'b0100;
    tick();
    req_valid = '0;
    repeat (3) tick();
    #1;
    chk("single_early", 32'(res_valid), 32'd0);
    tick();
    #1;
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_tag", 32'(res_tag), 32'd2);
    chk("single_data", res_data, 32'h40C0_0000);
    repeat (3) tick();

    // Backpressure: exactly RD accepts, then drain and re-enable
    res_ready  = 1'b0;
    req_lhs[1] = 32'h3FC0_0000;
    req_rhs[1] = 32'h3FC0_0000;
    req_valid  = 4'b0010;
    n_acc = 0;
    repeat (12) begin
      tick();
      n_acc += int'(obs_acc[1]);
    end
    chk("bp_accepts", 32'(n_acc), 32'(RD));
    #1;
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    res_ready = 1'b1;
    chk("bp_first_deq_valid", 32'(res_valid), 32'd1);
    chk("bp_first_deq_data", res_data, 32'h4010_0000);
    n_deq = 0;
    tick();
    n_deq += int'(obs_deq);
    #1;
    chk("bp_reenable", 32'(req_ready), 32'h2);
    req_valid = '0;
    repeat (10) begin
      tick();
      n_deq += int'(obs_deq);
    end
    chk("bp_drained", 32'(n_deq), 32'(RD));

    // Special case: inf * 0 -> quiet NaN, owned by requester 3
    req_lhs[3] = 32'h7F80_0000;
    req_rhs[3] = 32'h0000_0000;
    req_valid  = 4'b1000;
    tick();
    req_valid = '0;
    repeat (4) tick();
    #1;
    chk("special_valid", 32'(res_valid), 32'd1);
    chk("special_tag", 32'(res_tag), 32'd3);
    chk("special_data", res_data, 32'h7FC0_0000);
    repeat (3) tick();

    // Random stress with full-queue push/pop overlap, checked by the model
    for (int c = 0; c < 300; c++) begin
      rand_ops();
      req_valid = 4'($urandom);
      if (c < 20 || (c >= 150 && c < 170)) res_ready = 1'b0;
      else res_ready = ($urandom % 4) != 0;
      tick();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (12) tick();

    // Reset mid-operation with three operations in flight
    res_ready = 1'b0;
    req_valid = 4'hF;
    rand_ops();
    repeat (3) tick();
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst_n     = 1'b1;
    res_ready = 1'b1;
    n_stale = 0;
    repeat (10) begin
      tick();
      n_stale += int'(obs_deq);
    end
    chk("midrst_no_stale", 32'(n_stale), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
